// File: rtl/gate_exerciser_if.sv
// rtl/gate_exerciser_if.sv - control, status and gate-side signals of the gate exerciser
//
// Signals:
//   start, abort       sweep control, from the environment
//   C                  output of the gate under test
//   A, B               registered drive onto the gate inputs
//   busy, done, pass   sweep status
//   err_count          number of mismatching vectors (0..4)
//   fail_vec           bit k set when vector {A,B}=k mismatched
// Modports:
//   master  the exerciser side
//   slave   the environment side (controller plus gate under test)

interface gate_exerciser_if;
    logic       start;
    logic       abort;
    logic       C;
    logic       A;
    logic       B;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    modport master (
        input  start, abort, C,
        output A, B, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, abort, C,
        input  A, B, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - four-vector sweep and truth-table check of a 2-input gate
//
// Parameters:
//   HOLD_CYCLES  cycles each vector is held on A/B (>= 1)
//   FUNC         expected truth table indexed by {A,B}
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    gate_exerciser_if.master: start/abort in, C in, A/B out, status and results out

module gate_exerciser #(
    parameter int         HOLD_CYCLES = 5,
    parameter logic [3:0] FUNC        = 4'b1000
) (
    input  logic             clk,
    input  logic             rst_n,
    gate_exerciser_if.master bus
);

    localparam int             CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    vec;
    logic [CW-1:0] cnt;
    logic          a_q;
    logic          b_q;
    logic [2:0]    err_q;
    logic [3:0]    fail_q;

    logic accept;
    logic window_end;
    logic mismatch;

    // abort has priority over start, so a simultaneous pair is never accepted
    assign accept     = (state != RUN) && bus.start && !bus.abort;
    assign window_end = (state == RUN) && (cnt == CNT_LAST);
    assign mismatch   = (bus.C != FUNC[{a_q, b_q}]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (window_end && (vec == 2'd3)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state == RUN);
        bus.done      = (state == DONE);
        bus.pass      = (state == DONE) && (err_q == 3'd0);
        bus.A         = a_q;
        bus.B         = b_q;
        bus.err_count = err_q;
        bus.fail_vec  = fail_q;
    end

    // Sweep datapath: the gate output is judged on the last cycle of each
    // hold window, and the drive moves on to the next vector on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec    <= 2'd0;
            cnt    <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            err_q  <= 3'd0;
            fail_q <= 4'd0;
        end else if (accept) begin
            vec    <= 2'd0;
            cnt    <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            err_q  <= 3'd0;
            fail_q <= 4'd0;
        end else if (state == RUN) begin
            if (bus.abort) begin
                vec    <= 2'd0;
                cnt    <= '0;
                a_q    <= 1'b0;
                b_q    <= 1'b0;
                err_q  <= 3'd0;
                fail_q <= 4'd0;
            end else if (!window_end) begin
                cnt <= cnt + 1'b1;
            end else begin
                if (mismatch) begin
                    err_q       <= err_q + 3'd1;
                    fail_q[vec] <= 1'b1;
                end
                cnt <= '0;
                if (vec != 2'd3) begin
                    vec        <= vec + 2'd1;
                    {a_q, b_q} <= vec + 2'd1;
                end else begin
                    // leaving for DONE: park the gate inputs low, results freeze
                    {a_q, b_q} <= 2'b00;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// tb/tb_gate_exerciser.sv - randomized self-checking bench for gate_exerciser

module tb_gate_exerciser;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    gate_exerciser_if bus0 ();
    gate_exerciser_if bus1 ();

    // truth table of the emulated gate under test, per DUT
    logic [3:0] tt      [2];
    logic       start_r [2];
    logic       abort_r [2];

    assign bus0.start = start_r[0];
    assign bus0.abort = abort_r[0];
    assign bus0.C     = tt[0][{bus0.A, bus0.B}];
    assign bus1.start = start_r[1];
    assign bus1.abort = abort_r[1];
    assign bus1.C     = tt[1][{bus1.A, bus1.B}];

    gate_exerciser #(.HOLD_CYCLES(5), .FUNC(4'b1000)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    gate_exerciser #(.HOLD_CYCLES(1), .FUNC(4'b1110)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    logic [1:0] o_ab   [2];
    logic       o_busy [2];
    logic       o_done [2];
    logic       o_pass [2];
    logic [2:0] o_err  [2];
    logic [3:0] o_fail [2];

    assign o_ab[0]   = {bus0.A, bus0.B};
    assign o_busy[0] = bus0.busy;
    assign o_done[0] = bus0.done;
    assign o_pass[0] = bus0.pass;
    assign o_err[0]  = bus0.err_count;
    assign o_fail[0] = bus0.fail_vec;
    assign o_ab[1]   = {bus1.A, bus1.B};
    assign o_busy[1] = bus1.busy;
    assign o_done[1] = bus1.done;
    assign o_pass[1] = bus1.pass;
    assign o_err[1]  = bus1.err_count;
    assign o_fail[1] = bus1.fail_vec;

    int n_vec = 0;
    int n_bad = 0;

    // expected held results of each DUT when it is not sweeping
    logic       exp_done [2];
    logic [2:0] exp_err  [2];
    logic [3:0] exp_fail [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int sel);
        check($sformatf("idle%0d_busy", sel), o_busy[sel], 0);
        check($sformatf("idle%0d_done", sel), o_done[sel], exp_done[sel]);
        check($sformatf("idle%0d_pass", sel), o_pass[sel], exp_done[sel] && (exp_err[sel] == 0));
        check($sformatf("idle%0d_ab", sel),   o_ab[sel],   0);
        check($sformatf("idle%0d_err", sel),  o_err[sel],  exp_err[sel]);
        check($sformatf("idle%0d_fail", sel), o_fail[sel], exp_fail[sel]);
    endtask

    task automatic clear_exp(input int sel);
        exp_done[sel] = 1'b0;
        exp_err[sel]  = 3'd0;
        exp_fail[sel] = 4'd0;
    endtask

    // One sweep from an accepted start. abort_at / mid_start give the cycle
    // offset after E0 at which abort / a stray start are raised (-1 = never).
    task automatic sweep(input int sel, input logic [3:0] gate_tt, input int abort_at, input int mid_start);
        int         h;
        int         k;
        logic [3:0] func;
        logic [3:0] mism;
        logic [3:0] seen;
        h    = (sel != 0) ? 1 : 5;
        func = (sel != 0) ? 4'b1110 : 4'b1000;
        tt[sel] = gate_tt;
        mism = gate_tt ^ func;
        start_r[sel] = 1'b1;
        step();
        start_r[sel] = 1'b0;
        for (int t = 0; t < 4 * h; t++) begin
            k    = t / h;
            seen = mism & ((4'b0001 << k) - 4'b0001);
            check($sformatf("run%0d_ab_t%0d", sel, t),   o_ab[sel],   k);
            check($sformatf("run%0d_busy_t%0d", sel, t), o_busy[sel], 1);
            check($sformatf("run%0d_done_t%0d", sel, t), o_done[sel], 0);
            check($sformatf("run%0d_pass_t%0d", sel, t), o_pass[sel], 0);
            check($sformatf("run%0d_err_t%0d", sel, t),  o_err[sel],  $countones(seen));
            check($sformatf("run%0d_fail_t%0d", sel, t), o_fail[sel], seen);
            if (t == abort_at) begin
                abort_r[sel] = 1'b1;
                step();
                abort_r[sel] = 1'b0;
                clear_exp(sel);
                check_idle(sel);
                return;
            end
            if (t == mid_start) start_r[sel] = 1'b1;
            step();
            start_r[sel] = 1'b0;
        end
        exp_done[sel] = 1'b1;
        exp_err[sel]  = 3'($countones(mism));
        exp_fail[sel] = mism;
        check_idle(sel);
    endtask

    initial begin
        int sel;
        int h;
        int ab_at;
        int ms_at;
        for (int i = 0; i < 2; i++) begin
            tt[i]      = 4'b1000;
            start_r[i] = 1'b0;
            abort_r[i] = 1'b0;
            clear_exp(i);
        end

        // reset state
        repeat (3) step();
        check_idle(0);
        check_idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_idle(0);

        // ideal AND, stuck-at-0 (restart from DONE), stuck-at-1 with ignored mid start
        sweep(0, 4'b1000, -1, -1);
        sweep(0, 4'b0000, -1, -1);
        sweep(0, 4'b1111, -1, 9);

        // start+abort together in DONE: not accepted, results held
        start_r[0] = 1'b1;
        abort_r[0] = 1'b1;
        step();
        start_r[0] = 1'b0;
        check_idle(0);
        // abort alone in DONE: no effect
        step();
        abort_r[0] = 1'b0;
        step();
        check_idle(0);

        // abort at cycle 7, then start+abort in IDLE, then a full sweep
        sweep(0, 4'b1000, 7, -1);
        start_r[0] = 1'b1;
        abort_r[0] = 1'b1;
        step();
        start_r[0] = 1'b0;
        abort_r[0] = 1'b0;
        check_idle(0);
        sweep(0, 4'b1000, -1, -1);

        // H=1 exerciser expecting OR, driving an AND gate
        sweep(1, 4'b1000, -1, -1);
        sweep(1, 4'b1000, -1, 2);

        // randomized sweeps, aborts and idle-time noise
        repeat (16) begin
            sel   = int'($urandom_range(0, 1));
            h     = (sel != 0) ? 1 : 5;
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4 * h - 1)) : -1;
            ms_at = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4 * h - 1)) : -1;
            sweep(sel, 4'($urandom), ab_at, ms_at);
            repeat ($urandom_range(0, 2)) begin
                abort_r[sel] = 1'($urandom_range(0, 1));
                step();
            end
            abort_r[sel] = 1'b0;
            check_idle(sel);
        end

        // asynchronous reset between edges in the middle of a sweep
        tt[0]      = 4'b1111;
        start_r[0] = 1'b1;
        step();
        start_r[0] = 1'b0;
        repeat (8) step();
        #2;
        rst_n = 1'b0;
        #1;
        clear_exp(0);
        clear_exp(1);
        check_idle(0);
        check_idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_idle(0);
        check_idle(1);
        sweep(0, 4'b1000, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
